// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline sequencing controller.
// State encoding is visible on o_state, so the values are fixed.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam int DRAIN_CYCLES_DEF = 3;

    function automatic logic is_active(input state_e s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Shared by the sequencer and the debug unit.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_seq_ctrl.sv
// Run/step/stall/flush/halt-drain sequencer for the MIPS pipeline latches.
// Strobes are combinational from state and hazard inputs.
module pipeline_seq_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_pause,
    input  logic             i_step,
    input  logic             i_clear,
    input  logic             i_halt_instr,
    input  logic             i_load_stall,
    input  logic             i_branch_flush,
    output logic             o_en_pc,
    output logic             o_en_if_id,
    output logic             o_en_id_ex,
    output logic             o_en_ex_mem,
    output logic             o_en_mem_wb,
    output logic             o_flush_if_id,
    output logic             o_flush_id_ex,
    output logic             o_halted,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          halt_take;
    logic          cnt_en;
    logic          cnt_clr;

    // A load-use stall masks a HALT decoded in the same cycle.
    assign halt_take = i_halt_instr && !i_load_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    state_d = ST_RUN;
                end else if (i_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if (halt_take) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                end else if (state_q == ST_STEP || i_pause) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_HALTED: begin
                if (i_clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_en_pc       = 1'b0;
        o_en_if_id    = 1'b0;
        o_en_id_ex    = 1'b0;
        o_en_ex_mem   = 1'b0;
        o_en_mem_wb   = 1'b0;
        o_flush_if_id = 1'b0;
        o_flush_id_ex = 1'b0;
        unique case (state_q)
            ST_RUN, ST_STEP: begin
                o_en_pc     = 1'b1;
                o_en_if_id  = 1'b1;
                o_en_id_ex  = 1'b1;
                o_en_ex_mem = 1'b1;
                o_en_mem_wb = 1'b1;
                if (i_load_stall) begin
                    o_en_pc       = 1'b0;
                    o_en_if_id    = 1'b0;
                    o_flush_id_ex = 1'b1;
                end else if (i_halt_instr) begin
                    o_en_pc       = 1'b0;
                    o_flush_if_id = 1'b1;
                end else if (i_branch_flush) begin
                    o_flush_if_id = 1'b1;
                end
            end
            ST_DRAIN: begin
                o_en_ex_mem   = 1'b1;
                o_en_mem_wb   = 1'b1;
                o_flush_id_ex = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_halted = (state_q == ST_HALTED);
    assign o_state  = state_q;
    assign cnt_en   = is_active(state_q);
    assign cnt_clr  = (state_q == ST_HALTED) && i_clear;

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk  (clk),
        .rst_n(rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .count(o_cycle_cnt)
    );

endmodule

// File: tb/tb_pipeline_seq_ctrl.sv
// Scoreboard bench for pipeline_seq_ctrl: a default instance plus a
// CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_pipeline_seq_ctrl;

    typedef struct packed {
        logic [6:0] v;
        logic [2:0] st;
        logic       h;
    } exp_t;

    localparam logic [6:0] V_ZERO = 7'b0000000;
    localparam logic [6:0] V_ALL  = 7'b1111100;
    localparam logic [6:0] V_STL  = 7'b0011101;
    localparam logic [6:0] V_HLT  = 7'b0111110;
    localparam logic [6:0] V_BR   = 7'b1111110;
    localparam logic [6:0] V_DRN  = 7'b0001101;

    // stimulus bits: {run, pause, step, clear, halt, load_stall, branch_flush}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_RUN  = 7'b1000000;
    localparam logic [6:0] S_PAU  = 7'b0100000;
    localparam logic [6:0] S_STP  = 7'b0010000;
    localparam logic [6:0] S_CLR  = 7'b0001000;
    localparam logic [6:0] S_HLT  = 7'b0000100;
    localparam logic [6:0] S_LS   = 7'b0000010;
    localparam logic [6:0] S_BF   = 7'b0000001;

    logic clk;
    logic rst;
    logic run, pause, step, clr, halt, ls, bf;

    logic        en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic        fl_if_id, fl_id_ex, halted;
    logic [2:0]  state;
    logic [31:0] cnt;

    logic        d4_en_pc, d4_en_if_id, d4_en_id_ex, d4_en_ex_mem;
    logic        d4_en_mem_wb, d4_fl_if_id, d4_fl_id_ex, d4_halted;
    logic [2:0]  d4_state;
    logic [3:0]  cnt4;

    int   n_pass;
    int   n_total;
    exp_t sb[$];

    pipeline_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_run         (run),
        .i_pause       (pause),
        .i_step        (step),
        .i_clear       (clr),
        .i_halt_instr  (halt),
        .i_load_stall  (ls),
        .i_branch_flush(bf),
        .o_en_pc       (en_pc),
        .o_en_if_id    (en_if_id),
        .o_en_id_ex    (en_id_ex),
        .o_en_ex_mem   (en_ex_mem),
        .o_en_mem_wb   (en_mem_wb),
        .o_flush_if_id (fl_if_id),
        .o_flush_id_ex (fl_id_ex),
        .o_halted      (halted),
        .o_state       (state),
        .o_cycle_cnt   (cnt)
    );

    pipeline_seq_ctrl #(
        .CNT_W(4)
    ) dut4 (
        .clk           (clk),
        .rst           (rst),
        .i_run         (run),
        .i_pause       (pause),
        .i_step        (step),
        .i_clear       (clr),
        .i_halt_instr  (halt),
        .i_load_stall  (ls),
        .i_branch_flush(bf),
        .o_en_pc       (d4_en_pc),
        .o_en_if_id    (d4_en_if_id),
        .o_en_id_ex    (d4_en_id_ex),
        .o_en_ex_mem   (d4_en_ex_mem),
        .o_en_mem_wb   (d4_en_mem_wb),
        .o_flush_if_id (d4_fl_if_id),
        .o_flush_id_ex (d4_fl_id_ex),
        .o_halted      (d4_halted),
        .o_state       (d4_state),
        .o_cycle_cnt   (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t obs();
        return exp_t'({en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                       fl_if_id, fl_id_ex, state, halted});
    endfunction

    function automatic exp_t mk(input logic [6:0] v, input logic [2:0] st);
        return exp_t'({v, st, st == 3'd4});
    endfunction

    task automatic drive(input logic [6:0] s);
        @(posedge clk);
        #1;
        {run, pause, step, clr, halt, ls, bf} = s;
    endtask

    task automatic test_reset();
        exp_t got;
        rst = 1'b0;
        {run, pause, step, clr, halt, ls, bf} = S_NONE;
        #2;
        got = obs();
        n_total++;
        if (got !== mk(V_ZERO, 3'd0)) begin
            $display("FAIL reset outputs: got %b expected %b", got, mk(V_ZERO, 3'd0));
        end else n_pass++;
        n_total++;
        if (cnt !== 32'd0 || cnt4 !== 4'd0) begin
            $display("FAIL reset count: got %0d/%0d expected 0/0", cnt, cnt4);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_run();
        exp_t got, e;
        for (int i = 0; i < 12; i++) begin
            drive(i == 0 ? S_RUN : S_NONE);
            sb.push_back(i == 0 ? mk(V_ZERO, 3'd0) : mk(V_ALL, 3'd1));
            @(negedge clk);
            got = obs();
            e = sb.pop_front();
            n_total++;
            if (got !== e) begin
                $display("FAIL run step %0d: got %b expected %b", i, got, e);
            end else n_pass++;
        end
        n_total++;
        if (cnt !== 32'd10) begin
            $display("FAIL run count: got %0d expected 10", cnt);
        end else n_pass++;
    endtask

    task automatic test_hazards();
        exp_t got, e;
        logic [6:0] s [6];
        exp_t       x [6];
        s = '{S_LS | S_BF, S_BF, S_LS | S_HLT, S_STP, S_PAU, S_NONE};
        x = '{mk(V_STL, 3'd1), mk(V_BR, 3'd1), mk(V_STL, 3'd1),
              mk(V_ALL, 3'd1), mk(V_ALL, 3'd1), mk(V_ZERO, 3'd0)};
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            got = obs();
            e = sb.pop_front();
            n_total++;
            if (got !== e) begin
                $display("FAIL hazard step %0d: got %b expected %b", i, got, e);
            end else n_pass++;
        end
        n_total++;
        if (cnt !== 32'd16 || cnt4 !== 4'd15) begin
            $display("FAIL hazard count: got %0d/%0d expected 16/15", cnt, cnt4);
        end else n_pass++;
    endtask

    task automatic test_halt_drain();
        exp_t got, e;
        logic [6:0] s [10];
        exp_t       x [10];
        s = '{S_RUN, S_NONE, S_HLT, S_RUN | S_LS | S_BF, S_HLT, S_NONE,
              S_RUN, S_STP, S_CLR, S_NONE};
        x = '{mk(V_ZERO, 3'd0), mk(V_ALL, 3'd1), mk(V_HLT, 3'd1),
              mk(V_DRN, 3'd3), mk(V_DRN, 3'd3), mk(V_DRN, 3'd3),
              mk(V_ZERO, 3'd4), mk(V_ZERO, 3'd4), mk(V_ZERO, 3'd4),
              mk(V_ZERO, 3'd0)};
        for (int i = 0; i < 10; i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            got = obs();
            e = sb.pop_front();
            n_total++;
            if (got !== e) begin
                $display("FAIL halt step %0d: got %b expected %b", i, got, e);
            end else n_pass++;
            if (i == 7) begin
                n_total++;
                if (cnt !== 32'd21 || cnt4 !== 4'd15) begin
                    $display("FAIL halted count: got %0d/%0d expected 21/15", cnt, cnt4);
                end else n_pass++;
            end
        end
        n_total++;
        if (cnt !== 32'd0 || cnt4 !== 4'd0) begin
            $display("FAIL clear count: got %0d/%0d expected 0/0", cnt, cnt4);
        end else n_pass++;
    endtask

    task automatic test_step();
        exp_t got, e;
        logic [6:0] s [7];
        exp_t       x [7];
        s = '{S_STP, S_NONE, S_NONE, S_STP, S_NONE, S_NONE, S_NONE};
        x = '{mk(V_ZERO, 3'd0), mk(V_ALL, 3'd2), mk(V_ZERO, 3'd0),
              mk(V_ZERO, 3'd0), mk(V_ALL, 3'd2), mk(V_ZERO, 3'd0),
              mk(V_ZERO, 3'd0)};
        for (int i = 0; i < 7; i++) begin
            drive(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            got = obs();
            e = sb.pop_front();
            n_total++;
            if (got !== e) begin
                $display("FAIL step step %0d: got %b expected %b", i, got, e);
            end else n_pass++;
        end
        n_total++;
        if (cnt !== 32'd2) begin
            $display("FAIL step count: got %0d expected 2", cnt);
        end else n_pass++;
    endtask

    task automatic test_saturation();
        exp_t got, e;
        for (int i = 0; i < 22; i++) begin
            drive(i == 0 ? (S_RUN | S_STP) : (i == 21 ? S_HLT : S_NONE));
            sb.push_back(i == 0 ? mk(V_ZERO, 3'd0) :
                         (i == 21 ? mk(V_HLT, 3'd1) : mk(V_ALL, 3'd1)));
            @(negedge clk);
            got = obs();
            e = sb.pop_front();
            n_total++;
            if (got !== e) begin
                $display("FAIL sat step %0d: got %b expected %b", i, got, e);
            end else n_pass++;
        end
        n_total++;
        if (cnt !== 32'd22 || cnt4 !== 4'd15) begin
            $display("FAIL sat count: got %0d/%0d expected 22/15", cnt, cnt4);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        exp_t got, e;
        drive(S_NONE);
        @(negedge clk);
        got = obs();
        n_total++;
        if (got !== mk(V_DRN, 3'd3)) begin
            $display("FAIL pre-reset drain: got %b expected %b", got, mk(V_DRN, 3'd3));
        end else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        got = obs();
        n_total++;
        if (got !== mk(V_ZERO, 3'd0) || cnt !== 32'd0 || cnt4 !== 4'd0) begin
            $display("FAIL async reset: got %b cnt %0d expected %b cnt 0",
                     got, cnt, mk(V_ZERO, 3'd0));
        end else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(i == 3 ? S_RUN : S_NONE);
            sb.push_back(i == 4 ? mk(V_ALL, 3'd1) : mk(V_ZERO, 3'd0));
            @(negedge clk);
            got = obs();
            e = sb.pop_front();
            n_total++;
            if (got !== e) begin
                $display("FAIL post-reset step %0d: got %b expected %b", i, got, e);
            end else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_run();
        test_hazards();
        test_halt_drain();
        test_step();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
